// File: rtl/ad7980_pkg.sv
// Shared types and default sizing for the AD7980 serial-port emulator.
package ad7980_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        WAIT_CS = 2'd2,
        SHIFT   = 2'd3
    } ad7980_state_t;

    localparam int DEFAULT_BITS        = 16;
    localparam int DEFAULT_TCONV_CNT   = 40;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/ad7980_emulator_if.sv
// Three-wire AD7980 pin bundle: the controller drives cnv/sck, the converter returns sdo.
interface ad7980_emulator_if;

    logic cnv;
    logic sck;
    logic sdo;
    logic sdo_oe;

    modport master (output cnv, output sck, input sdo, input sdo_oe);
    modport slave  (input cnv, input sck, output sdo, output sdo_oe);

endinterface

// File: rtl/ad7980_emulator_edge_sync.sv
// Multi-flop synchroniser with a history flop producing registered rise/fall pulses.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              hist_reg;
    logic              rise_reg;
    logic              fall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            hist_reg <= sync_reg[STAGES-1];
            rise_reg <= sync_reg[STAGES-1] & ~hist_reg;
            fall_reg <= ~sync_reg[STAGES-1] & hist_reg;
        end
    end

    // The history flop is exported as the level so it lines up with the pulses.
    assign level = hist_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/ad7980_emulator.sv
// AD7980 CS-mode responder: models conversion time and shifts a latched sample out MSB first.
module ad7980_emulator
    import ad7980_pkg::*;
#(
    parameter int BITS        = DEFAULT_BITS,
    parameter int TCONV_CNT   = DEFAULT_TCONV_CNT,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    ad7980_emulator_if.slave    bus,
    input  logic [BITS-1:0]     sample_in,
    output logic                conv_busy,
    output logic                sample_req,
    output logic                frame_done
);

    localparam int BCW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int TCW = $clog2(TCONV_CNT + 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(BITS - 1);
    localparam logic [TCW-1:0] TCONV_LAST = TCW'(TCONV_CNT - 1);

    logic cnv_s, cnv_rise, cnv_fall;
    logic sck_s, sck_rise, sck_fall;

    edge_sync #(.STAGES(SYNC_STAGES)) u_cnv_sync (
        .clk(clk), .rst(rst), .din(bus.cnv),
        .level(cnv_s), .rise(cnv_rise), .fall(cnv_fall)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk), .rst(rst), .din(bus.sck),
        .level(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    logic unused_sck;
    assign unused_sck = &{1'b0, sck_s, sck_rise};

    ad7980_state_t   state_reg, state_next;
    logic [BITS-1:0] shift_reg, shift_next;
    logic [BCW-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [TCW-1:0]  tconv_cnt_reg, tconv_cnt_next;
    logic            sdo_reg, sdo_next;
    logic            sdo_oe_reg, sdo_oe_next;
    logic            conv_busy_reg, conv_busy_next;
    logic            sample_req_reg, sample_req_next;
    logic            frame_done_reg, frame_done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            tconv_cnt_reg  <= '0;
            sdo_reg        <= 1'b0;
            sdo_oe_reg     <= 1'b0;
            conv_busy_reg  <= 1'b0;
            sample_req_reg <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            tconv_cnt_reg  <= tconv_cnt_next;
            sdo_reg        <= sdo_next;
            sdo_oe_reg     <= sdo_oe_next;
            conv_busy_reg  <= conv_busy_next;
            sample_req_reg <= sample_req_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        tconv_cnt_next  = tconv_cnt_reg;
        sdo_next        = sdo_reg;
        sdo_oe_next     = sdo_oe_reg;
        conv_busy_next  = conv_busy_reg;
        sample_req_next = 1'b0;
        frame_done_next = 1'b0;

        // A new conversion request restarts from any state and beats a coincident sck edge.
        if (cnv_rise) begin
            state_next      = CONVERT;
            shift_next      = sample_in;
            sample_req_next = 1'b1;
            conv_busy_next  = 1'b1;
            tconv_cnt_next  = '0;
            bit_cnt_next    = '0;
            sdo_next        = 1'b0;
            sdo_oe_next     = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    sdo_next    = 1'b0;
                    sdo_oe_next = 1'b0;
                end
                CONVERT: begin
                    if (tconv_cnt_reg == TCONV_LAST) begin
                        conv_busy_next = 1'b0;
                        if (!cnv_s) begin
                            state_next   = SHIFT;
                            sdo_next     = shift_reg[BITS-1];
                            sdo_oe_next  = 1'b1;
                            bit_cnt_next = '0;
                        end else begin
                            state_next = WAIT_CS;
                        end
                    end else begin
                        tconv_cnt_next = tconv_cnt_reg + 1'b1;
                    end
                end
                WAIT_CS: begin
                    if (cnv_fall) begin
                        state_next   = SHIFT;
                        sdo_next     = shift_reg[BITS-1];
                        sdo_oe_next  = 1'b1;
                        bit_cnt_next = '0;
                    end
                end
                SHIFT: begin
                    if (sck_fall) begin
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_next      = IDLE;
                            sdo_next        = 1'b0;
                            sdo_oe_next     = 1'b0;
                            frame_done_next = 1'b1;
                        end else begin
                            shift_next   = {shift_reg[BITS-2:0], 1'b0};
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                            sdo_next     = shift_reg[BITS-2];
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.sdo    = sdo_reg;
    assign bus.sdo_oe = sdo_oe_reg;
    assign conv_busy  = conv_busy_reg;
    assign sample_req = sample_req_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ad7980_emulator.sv
// Scenario bench for ad7980_emulator acting as a read controller against a frame-level model.
module tb_ad7980_emulator;

    localparam int BITS  = 16;
    localparam int TCONV = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample_in = '0;
    logic        conv_busy, sample_req, frame_done;

    ad7980_emulator_if bus ();

    ad7980_emulator #(.BITS(BITS), .TCONV_CNT(TCONV), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sample_in  (sample_in),
        .conv_busy  (conv_busy),
        .sample_req (sample_req),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Pulse/run monitors sampled on the falling edge, away from register updates.
    int req_cnt = 0, fd_cnt = 0, busy_runs = 0, busy_run = 0, last_busy = 0;
    always @(negedge clk) begin
        if (sample_req) req_cnt <= req_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (conv_busy) begin
            busy_run <= busy_run + 1;
        end else if (busy_run != 0) begin
            last_busy <= busy_run;
            busy_runs <= busy_runs + 1;
            busy_run  <= 0;
        end
    end

    // Model: a frame is the latched sample MSB first, then zeros; oe covers exactly BITS bits.
    function automatic logic [31:0] exp_word(input logic [15:0] s, input int nbits);
        logic [31:0] w;
        w = 32'(s);
        return (nbits >= BITS) ? (w << (nbits - BITS)) : (w >> (BITS - nbits));
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_conv(input logic [15:0] s, input int high_t);
        sample_in = s;
        bus.cnv = 1'b1;
        tick(high_t);
        bus.cnv = 1'b0;
        tick((high_t >= 22) ? 6 : 28 - high_t);
    endtask

    task automatic read_frame(input int nbits, input int hi, input int lo,
                              output logic [31:0] data, output logic [31:0] oe);
        data = '0;
        oe   = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.sck = 1'b1;
            data = {data[30:0], bus.sdo};
            oe   = {oe[30:0], bus.sdo_oe};
            tick(hi);
            bus.sck = 1'b0;
            tick(lo);
        end
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        rst = 1'b1;
        bus.cnv = 1'b0;
        bus.sck = 1'b0;
        tick(4);
        outs = {bus.sdo, bus.sdo_oe, conv_busy, sample_req, frame_done};
        n_vec++;
        if (outs !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 00000", outs);
        end
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_loopback(input logic [15:0] s, input int high_t, input int hi, input int lo,
                                 input string tag);
        logic [31:0] data, oe;
        int r0, f0, b0;
        r0 = req_cnt; f0 = fd_cnt; b0 = busy_runs;
        start_conv(s, high_t);
        read_frame(BITS, hi, lo, data, oe);
        tick(4);
        n_vec++;
        if (data !== exp_word(s, BITS)) begin
            n_err++;
            $display("FAIL %s_data: got %h expected %h", tag, data, exp_word(s, BITS));
        end
        n_vec++;
        if (oe !== 32'h0000_FFFF || bus.sdo_oe !== 1'b0) begin
            n_err++;
            $display("FAIL %s_oe: got bits %h final %b expected 0000ffff final 0", tag, oe, bus.sdo_oe);
        end
        n_vec++;
        if (req_cnt - r0 != 1 || fd_cnt - f0 != 1) begin
            n_err++;
            $display("FAIL %s_pulses: got req %0d done %0d expected 1 1", tag, req_cnt - r0, fd_cnt - f0);
        end
        n_vec++;
        if (busy_runs - b0 != 1 || last_busy != TCONV) begin
            n_err++;
            $display("FAIL %s_busy: got runs %0d len %0d expected 1 %0d", tag, busy_runs - b0, last_busy, TCONV);
        end
        $display("frame %s sample=%h read=%h oe=%h", tag, s, data, oe);
    endtask

    task automatic test_early_cs();
        logic [15:0] s;
        logic [31:0] data, oe;
        int k, bad;
        s = 16'($urandom);
        sample_in = s;
        bus.cnv = 1'b1;
        k = 0;
        while (conv_busy !== 1'b1 && k < 10) begin
            tick(1);
            k++;
        end
        tick(5);
        bus.cnv = 1'b0;
        bad = 0;
        k = 0;
        while (conv_busy === 1'b1 && k < 40) begin
            if (bus.sdo_oe !== 1'b0) bad = 1;
            tick(1);
            k++;
        end
        n_vec++;
        if (bad != 0 || conv_busy !== 1'b0 || k == 0) begin
            n_err++;
            $display("FAIL early_cs_oe_during_busy: got bad=%0d busy=%b cycles=%0d expected 0 0 >0", bad, conv_busy, k);
        end
        n_vec++;
        if (bus.sdo_oe !== 1'b1 || bus.sdo !== s[15]) begin
            n_err++;
            $display("FAIL early_cs_msb: got oe=%b sdo=%b expected 1 %b", bus.sdo_oe, bus.sdo, s[15]);
        end
        tick(4);
        read_frame(BITS, 8, 8, data, oe);
        n_vec++;
        if (data !== exp_word(s, BITS)) begin
            n_err++;
            $display("FAIL early_cs_data: got %h expected %h", data, exp_word(s, BITS));
        end
        $display("frame early_cs sample=%h read=%h", s, data);
        tick(4);
    endtask

    task automatic test_abort();
        logic [31:0] data, oe;
        int f0, r0;
        start_conv(16'hFFFF, 30);
        read_frame(7, 8, 8, data, oe);
        f0 = fd_cnt; r0 = req_cnt;
        sample_in = 16'h1234;
        bus.cnv = 1'b1;
        tick(5);
        n_vec++;
        if (bus.sdo_oe !== 1'b0 || bus.sdo !== 1'b0 || req_cnt - r0 != 1) begin
            n_err++;
            $display("FAIL abort_outputs: got oe=%b sdo=%b req=%0d expected 0 0 1", bus.sdo_oe, bus.sdo, req_cnt - r0);
        end
        tick(25);
        bus.cnv = 1'b0;
        tick(6);
        n_vec++;
        if (fd_cnt != f0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d frame_done expected 0", fd_cnt - f0);
        end
        read_frame(BITS, 8, 8, data, oe);
        tick(4);
        n_vec++;
        if (data !== 32'h0000_1234 || fd_cnt - f0 != 1) begin
            n_err++;
            $display("FAIL abort_next_frame: got %h done %0d expected 00001234 1", data, fd_cnt - f0);
        end
        $display("frame abort_restart read=%h", data);
    endtask

    task automatic test_overrun();
        logic [31:0] data, oe;
        int f0;
        f0 = fd_cnt;
        start_conv(16'h00FF, 30);
        read_frame(24, 8, 8, data, oe);
        tick(4);
        n_vec++;
        if (data !== exp_word(16'h00FF, 24) || oe !== 32'h00FF_FF00) begin
            n_err++;
            $display("FAIL overrun_data: got %h oe %h expected %h oe 00ffff00", data, oe, exp_word(16'h00FF, 24));
        end
        n_vec++;
        if (fd_cnt - f0 != 1) begin
            n_err++;
            $display("FAIL overrun_done: got %0d expected 1", fd_cnt - f0);
        end
        $display("frame overrun24 read=%h oe=%h", data, oe);
    endtask

    task automatic test_reset_mid();
        logic [31:0] data, oe;
        logic [4:0]  outs;
        logic [15:0] s;
        int f0;
        start_conv(16'($urandom), 30);
        read_frame(10, 8, 8, data, oe);
        f0 = fd_cnt;
        rst = 1'b1;
        tick(1);
        outs = {bus.sdo, bus.sdo_oe, conv_busy, sample_req, frame_done};
        n_vec++;
        if (outs !== 5'b0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %b expected 00000", outs);
        end
        tick(2);
        rst = 1'b0;
        tick(3);
        read_frame(3, 6, 6, data, oe);
        n_vec++;
        if (oe !== 32'h0 || fd_cnt != f0) begin
            n_err++;
            $display("FAIL reset_mid_idle: got oe %h done %0d expected 0 0", oe, fd_cnt - f0);
        end
        s = 16'($urandom);
        start_conv(s, 30);
        read_frame(BITS, 8, 8, data, oe);
        tick(4);
        n_vec++;
        if (data !== exp_word(s, BITS) || fd_cnt - f0 != 1) begin
            n_err++;
            $display("FAIL reset_mid_next: got %h done %0d expected %h 1", data, fd_cnt - f0, exp_word(s, BITS));
        end
        $display("frame after_reset sample=%h read=%h", s, data);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            test_loopback(16'($urandom), $urandom_range(2, 40), $urandom_range(3, 8),
                          $urandom_range(5, 8), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        bus.cnv = 1'b0;
        bus.sck = 1'b0;
        test_reset();
        test_loopback(16'hA5C3, 30, 8, 8, "loopback");
        test_loopback(16'h8001, 50, 8, 8, "direct");
        test_early_cs();
        test_abort();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
